// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_pkg                                                     |
// | Shared FSM encodings, starve-counter width and helpers for the arbiter.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_DM = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                      |
// | IF port, MEM-stage port and unified-memory bus seen by the arbiter.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [STRB_W-1:0] dm_wstrb;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata, if_stall,
    output dm_ack, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Pipeline stages and memory side
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata, if_stall,
    input  dm_ack, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_pick                                                                 |
// | Combinational IF/DM pick: DM first unless force_if; grant one-hot/zero.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic force_if,
  output logic gnt_if,
  output logic gnt_dm
);

  // force_if only overrides DM when IF is actually waiting, so a lone DM
  // request is never blocked by a saturated starve count.
  assign gnt_dm = dm_req & ~(force_if & if_req);
  assign gnt_if = if_req & ~gnt_dm;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one variable-latency memory between fetch and load/store ports.   |
// | Optional fairness (IF anti-starvation) enabled by macro ARB_FAIR_EN.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  if ((STARVE_MAX < 1) || (STARVE_MAX > (2 ** CNT_W) - 1)) begin : g_starve_range_err
    $error("STARVE_MAX must be in 1..15");
  end

  arb_state_e        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic force_if;
  logic gnt_if;
  logic gnt_dm;

`ifdef ARB_FAIR_EN
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (gnt_if) begin
        starve_d = '0;
      end else if (gnt_dm && bus.if_req) begin
        starve_d = sat_inc(starve_q, STARVE_LIM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  arb_pick u_arb_pick (
    .if_req   (bus.if_req),
    .dm_req   (bus.dm_req),
    .force_if (force_if),
    .gnt_if   (gnt_if),
    .gnt_dm   (gnt_dm)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_dm) begin
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_wstrb_d = bus.dm_wstrb;
          state_d     = ARB_GNT_DM;
        end else if (gnt_if) begin
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          state_d     = ARB_GNT_IF;
        end
      end
      ARB_GNT_IF: begin
        if (bus.mem_ready) begin
          if_rdata_d = bus.mem_rdata;
          if_ack_d   = 1'b1;
          state_d    = ARB_DONE;
        end
      end
      ARB_GNT_DM: begin
        if (bus.mem_ready) begin
          // Stores leave the last load result visible on dm_rdata.
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
          dm_ack_d = 1'b1;
          state_d  = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.mem_req   = (state_q == ARB_GNT_IF) || (state_q == ARB_GNT_DM);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign bus.if_ack   = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_stall = bus.if_req & ~if_ack_q;

  assign bus.dm_ack   = dm_ack_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.dm_stall = bus.dm_req & ~dm_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Scoreboard bench: requesters, behavioural memory, per-cycle monitor.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } dm_exp_t;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  dm_exp_t     dm_q [$];
  logic [31:0] if_q [$];
  int          order_q [$];
  logic [31:0] exp_dm_hold = '0;
  int          mem_lat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  // Behavioural memory: ready after mem_lat extra cycles, fields must hold.
  initial begin : p_memory
    int          cnt;
    logic [31:0] rec_addr, rec_wdata;
    logic [3:0]  rec_wstrb;
    logic        rec_we;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hBAD0_BAD0;
      if (bus.mem_req === 1'b1) begin
        if (cnt == 0) begin
          rec_addr = bus.mem_addr; rec_wdata = bus.mem_wdata;
          rec_wstrb = bus.mem_wstrb; rec_we = bus.mem_we;
        end else begin
          check("mem_addr_stable", bus.mem_addr, rec_addr);
          check("mem_ctl_stable", {27'd0, bus.mem_we, bus.mem_wstrb}, {27'd0, rec_we, rec_wstrb});
          check("mem_wdata_stable", bus.mem_wdata, rec_wdata);
        end
        if (cnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) mdl_mem[bus.mem_addr] = merge(mdl_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
          else bus.mem_rdata = mdl_rd(bus.mem_addr);
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle invariants and scoreboard pops.
  initial begin : p_monitor
    logic        prev_ack;
    logic [31:0] mon_if_hold, mon_dm_hold;
    dm_exp_t     e;
    prev_ack = 1'b0; mon_if_hold = '0; mon_dm_hold = '0;
    forever begin
      @(negedge clk);
      check("ack_exclusive", 32'(bus.if_ack & bus.dm_ack), 32'd0);
      check("mem_req_in_done", 32'(bus.mem_req & (bus.if_ack | bus.dm_ack)), 32'd0);
      check("mem_req_after_done", 32'(bus.mem_req & prev_ack), 32'd0);
      prev_ack = bus.if_ack | bus.dm_ack;
      if (rst) begin
        mon_if_hold = '0; mon_dm_hold = '0;
      end else begin
        if (bus.dm_ack === 1'b1) begin
          check("dm_ack_expected", 32'(dm_q.size() != 0), 32'd1);
          if (dm_q.size() != 0) begin
            e = dm_q.pop_front();
            check("dm_rdata", bus.dm_rdata, e.data);
            check("if_rdata_hold", bus.if_rdata, mon_if_hold);
            mon_dm_hold = e.data;
            order_q.push_back(1);
          end
        end
        if (bus.if_ack === 1'b1) begin
          check("if_ack_expected", 32'(if_q.size() != 0), 32'd1);
          if (if_q.size() != 0) begin
            mon_if_hold = if_q.pop_front();
            check("if_rdata", bus.if_rdata, mon_if_hold);
            check("dm_rdata_hold", bus.dm_rdata, mon_dm_hold);
            order_q.push_back(0);
          end
        end
      end
    end
  end

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
    dm_exp_t e;
    if (we) begin
      exp_mem[addr] = merge(exp_rd(addr), wdata, strb);
    end else begin
      exp_dm_hold = exp_rd(addr);
    end
    e.we = we; e.data = exp_dm_hold;
    dm_q.push_back(e);
  endtask

  // Called at posedge+1 with the arbiter idle; returns one idle cycle later.
  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int lat, input logic [31:0] alt_addr);
    int   cyc;
    logic got;
    mem_lat = lat;
    push_dm(we, addr, wdata, strb);
    bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata; bus.dm_wstrb = strb;
    bus.dm_req = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("dm_mem_req", 32'(bus.mem_req), 32'd1);
        check("dm_mem_we", 32'(bus.mem_we), 32'(we));
        check("dm_mem_addr", bus.mem_addr, addr);
        check("dm_mem_wstrb", 32'(bus.mem_wstrb), 32'(strb));
        if (we) check("dm_mem_wdata", bus.mem_wdata, wdata);
        if (alt_addr != 32'd0) bus.dm_addr = alt_addr;
      end
      if (bus.dm_ack === 1'b1) got = 1'b1;
    end
    check("dm_ack_seen", 32'(got), 32'd1);
    check("dm_latency", 32'(cyc), 32'(lat + 2));
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wstrb = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_if(input logic [31:0] addr, input int lat);
    int   cyc;
    logic got;
    mem_lat = lat;
    if_q.push_back(exp_rd(addr));
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("if_mem_req", 32'(bus.mem_req), 32'd1);
        check("if_mem_we", 32'(bus.mem_we), 32'd0);
        check("if_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("if_mem_addr", bus.mem_addr, addr);
      end
      if (bus.if_ack === 1'b1) got = 1'b1;
      else if (bus.dm_ack !== 1'b1) check("if_stall_wait", 32'(bus.if_stall), 32'd1);
    end
    check("if_ack_seen", 32'(got), 32'd1);
    check("if_latency", 32'(cyc), 32'(lat + 2));
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int   n_acks;
    logic stall_low;
    int   exp_order [5];

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0;
    bus.dm_wdata = '0; bus.dm_wstrb = '0;
    exp_mem[32'h40] = 32'h0050_0093;
    mdl_mem[32'h40] = 32'h0050_0093;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_dm_rdata", bus.dm_rdata, 32'd0);
    rst = 1'b0;

    do_dm(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 32'd0);
    do_if(32'h40, 3);
    do_dm(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'd0);
    do_dm(1'b1, 32'h100, 32'h1122_3344, 4'b0101, 2, 32'd0);
    do_dm(1'b0, 32'h100, 32'd0, 4'h0, 0, 32'd0);
    do_if(32'h44, 0);
    // Address changes mid-grant must not reach the memory.
    do_dm(1'b0, 32'h100, 32'd0, 4'h0, 3, 32'h200);

    // Both ports requesting continuously.
    order_q.delete();
`ifdef ARB_FAIR_EN
    exp_order = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 4; i++) push_dm(1'b0, 32'h80, 32'd0, 4'h0);
    if_q.push_back(exp_rd(32'h44));
`else
    exp_order = '{1, 1, 1, 1, 1};
    for (int i = 0; i < 5; i++) push_dm(1'b0, 32'h80, 32'd0, 4'h0);
`endif
    mem_lat = 1;
    bus.if_addr = 32'h44; bus.if_req = 1'b1;
    bus.dm_we = 1'b0; bus.dm_addr = 32'h80; bus.dm_wstrb = '0; bus.dm_req = 1'b1;
    n_acks = 0; stall_low = 1'b0;
    for (int c = 0; c < 80 && n_acks < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_stall !== 1'b1) stall_low = 1'b1;
      if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) n_acks++;
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_grants", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++) check("t3_order", 32'(order_q[i]), 32'(exp_order[i]));
`ifndef ARB_FAIR_EN
    check("t3_if_stall_held", 32'(stall_low), 32'd0);
`endif

    // Reset while the memory is still busy with a DM access.
    mem_lat = 10;
    bus.dm_we = 1'b0; bus.dm_addr = 32'h300; bus.dm_wstrb = '0; bus.dm_req = 1'b1;
    @(posedge clk);
    #1;
    check("t4_in_gnt", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; bus.dm_req = 1'b0;
    @(posedge clk);
    #1;
    check("t4_mem_req", 32'(bus.mem_req), 32'd0);
    check("t4_dm_ack", 32'(bus.dm_ack), 32'd0);
    check("t4_mem_addr", bus.mem_addr, 32'd0);
    check("t4_dm_rdata", bus.dm_rdata, 32'd0);
    rst = 1'b0;
    exp_dm_hold = '0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_late_ack", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    check("t4_idle_mem_req", 32'(bus.mem_req), 32'd0);

    do_dm(1'b0, 32'h100, 32'd0, 4'h0, 0, 32'd0);
    do_if(32'h40, 1);

    repeat (2) @(posedge clk);
    #1;
    check("dm_q_drained", 32'(dm_q.size()), 32'd0);
    check("if_q_drained", 32'(if_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
